// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds the hex value shown on a multiplexed 8-digit active-low seven-segment bus
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter logic [7:0] DIGIT_MASK = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sa,
    input  logic        sb,
    input  logic        sc,
    input  logic        sd,
    input  logic        se,
    input  logic        sf,
    input  logic        sg,
    input  logic        dp,
    input  logic [7:0]  an,
    output logic [31:0] digits,
    output logic [7:0]  digit_valid,
    output logic [7:0]  dp_out,
    output logic        frame_done,
    output logic        err_pattern,
    output logic        err_multi
);
    localparam logic [3:0] S = 4'(STABLE_CYCLES);
    logic [15:0] sample_q, prev_q;
    logic        sv_q, pv_q, same, acc;
    logic [3:0]  cnt_q, cnt_n;
    logic [7:0]  sel, seen_q, seen_n, valid_n, dp_n;
    logic        blank, single, multi, legal, hit, done;
    logic [6:0]  p;
    logic [3:0]  nib;
    logic [31:0] digits_n;
    // sample the bus; sv_q/pv_q mark sample_q/prev_q as holding real post-reset samples
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
            prev_q   <= '0;
            sv_q     <= 1'b0;
            pv_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sample_q <= {an, dp, sg, sf, se, sd, sc, sb, sa};
            prev_q   <= sample_q;
            sv_q     <= 1'b1;
            pv_q     <= sv_q;
            cnt_q    <= cnt_n;
        end
    end
    // stability run counter; acceptance fires once when the run reaches S
    always_comb begin
        same  = pv_q && sample_q == prev_q;
        cnt_n = !sv_q ? 4'd0 : !same ? 4'd1 : cnt_q == S ? S : cnt_q + 4'd1;
        acc   = sv_q && cnt_n == S && (cnt_q != S || !same);
    end
    // classify the anode field and decode the glyph of the accepted sample
    always_comb begin
        sel    = ~sample_q[15:8];
        blank  = sel == 8'd0;
        single = !blank && (sel & (sel - 8'd1)) == 8'd0;
        multi  = !blank && !single;
        p      = ~sample_q[6:0];
        legal  = 1'b1;
        nib    = 4'h0;
        case (p)
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: legal = 1'b0;
        endcase
    end
    // next digit/valid/dp/seen state for a single-anode acceptance
    always_comb begin
        hit      = acc && single;
        digits_n = digits;
        valid_n  = digit_valid;
        dp_n     = dp_out;
        seen_n   = seen_q | sel;
        for (int i = 0; i < 8; i++) begin
            if (hit && sel[i]) begin
                digits_n[4*i+:4] = legal ? nib : digits[4*i+:4];
                valid_n[i]       = legal;
                dp_n[i]          = legal ? ~sample_q[7] : dp_out[i];
            end
        end
        done = hit && (seen_n & DIGIT_MASK) == DIGIT_MASK;
    end
    // register decoded state and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            digits      <= '0;
            digit_valid <= '0;
            dp_out      <= '0;
            seen_q      <= '0;
            frame_done  <= 1'b0;
            err_pattern <= 1'b0;
            err_multi   <= 1'b0;
        end else begin
            digits      <= digits_n;
            digit_valid <= valid_n;
            dp_out      <= dp_n;
            seen_q      <= done ? 8'd0 : hit ? seen_n : seen_q;
            frame_done  <= done;
            err_pattern <= hit && !legal;
            err_multi   <= acc && multi;
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed checks of the seven-segment scan decoder
module tb_seg_scan_decoder;
    logic        clk = 1'b0, rst = 1'b1;
    logic        sa, sb, sc, sd, se, sf, sg, dp;
    logic [7:0]  an;
    logic [31:0] digits;
    logic [7:0]  digit_valid, dp_out;
    logic        frame_done, err_pattern, err_multi;
    int          n_chk = 0, n_err = 0, fd_n = 0, ep_n = 0, em_n = 0;
    logic [6:0]  glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          ord [8] = '{4, 5, 6, 7, 0, 1, 2, 3};

    seg_scan_decoder dut (
        .clk(clk), .rst(rst),
        .sa(sa), .sb(sb), .sc(sc), .sd(sd), .se(se), .sf(sf), .sg(sg),
        .dp(dp), .an(an),
        .digits(digits), .digit_valid(digit_valid), .dp_out(dp_out),
        .frame_done(frame_done), .err_pattern(err_pattern), .err_multi(err_multi)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [6:0] p, input logic lit);
        an = a;
        {sg, sf, se, sd, sc, sb, sa} = ~p;
        dp = ~lit;
    endtask

    task automatic rand_bus();
        {an, dp, sg, sf, se, sd, sc, sb, sa} = 16'($urandom);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            fd_n += int'(frame_done);
            ep_n += int'(err_pattern);
            em_n += int'(err_multi);
        end
    endtask

    task automatic clr();
        fd_n = 0;
        ep_n = 0;
        em_n = 0;
    endtask

    task automatic show(input int k, input int v, input logic lit, input int cyc);
        drive(~(8'b1 << k), glyph[v], lit);
        run(cyc);
    endtask

    initial begin
        rand_bus();
        run(1);
        rand_bus();
        run(1);
        chk("rst digits", digits, 32'h0);
        chk("rst valid", {24'h0, digit_valid}, 32'h0);
        chk("rst dp", {24'h0, dp_out}, 32'h0);
        rst = 1'b0;
        rand_bus();
        clr();
        run(4);
        chk("post-rst pulses", fd_n + ep_n + em_n, 0);
        chk("post-rst digits", digits, 32'h0);
        chk("post-rst valid", {24'h0, digit_valid}, 32'h0);
        drive(8'hFF, 7'h00, 1'b0);
        run(6);
        clr();
        show(0, 1, 1'b0, 4);
        chk("d0 early", digits, 32'h0);
        run(1);
        chk("d0 digits", digits, 32'h1);
        chk("d0 valid", {24'h0, digit_valid}, 32'h01);
        chk("d0 dp", {24'h0, dp_out}, 32'h0);
        chk("d0 frame", fd_n, 0);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        clr();
        for (int i = 0; i < 8; i++) begin
            show(7 - i, 8 - i, (7 - i) == 3, 6);
            chk($sformatf("scan d%0d frame", 7 - i), fd_n, (i == 7) ? 1 : 0);
        end
        chk("scan digits", digits, 32'h87654321);
        chk("scan valid", {24'h0, digit_valid}, 32'hFF);
        chk("scan dp", {24'h0, dp_out}, 32'h08);
        show(2, 10, 1'b0, 6);
        chk("d2 A", digits, 32'h87654A21);
        clr();
        drive(8'hFB, 7'h79, 1'b0);
        run(2);
        chk("glitch digits", digits, 32'h87654A21);
        show(2, 10, 1'b0, 6);
        chk("glitch pulses", fd_n + ep_n + em_n, 0);
        chk("glitch valid", {24'h0, digit_valid}, 32'hFF);
        clr();
        drive(8'hFC, glyph[3], 1'b0);
        run(6);
        chk("multi em", em_n, 1);
        chk("multi others", fd_n + ep_n, 0);
        chk("multi digits", digits, 32'h87654A21);
        chk("multi valid", {24'h0, digit_valid}, 32'hFF);
        clr();
        drive(8'hFB, 7'h27, 1'b0);
        run(6);
        chk("pat ep", ep_n, 1);
        chk("pat em", em_n, 0);
        chk("pat valid", {24'h0, digit_valid}, 32'hFB);
        chk("pat digits", digits, 32'h87654A21);
        chk("pat dp", {24'h0, dp_out}, 32'h08);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        clr();
        for (int k = 0; k < 4; k++) show(k, 5, 1'b0, 6);
        chk("pre digits", digits, 32'h00005555);
        chk("pre frame", fd_n, 0);
        rst = 1'b1;
        run(1);
        chk("mid rst digits", digits, 32'h0);
        chk("mid rst valid", {24'h0, digit_valid}, 32'h0);
        rst = 1'b0;
        clr();
        for (int i = 0; i < 8; i++) begin
            show(ord[i], (ord[i] + 9) % 16, 1'b0, 6);
            chk($sformatf("rescan d%0d frame", ord[i]), fd_n, (i == 7) ? 1 : 0);
        end
        chk("rescan digits", digits, 32'h0FEDCBA9);
        chk("rescan valid", {24'h0, digit_valid}, 32'hFF);
        chk("rescan dp", {24'h0, dp_out}, 32'h0);
        chk("rescan errs", ep_n + em_n, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
